if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter QUEUE_DEPTH, default 4, meaning prefetch queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port branch_enable, input, 1 bit: redirect or flush request.
REQ-006 The block SHALL have port branch_target, input, 32 bits: the redirect PC.
REQ-007 The block SHALL have port mem_ctrl_busy_mem_in, input, 1 bit: the memory controller is serving the MEM stage.
REQ-008 The block SHALL have port mem_ctrl_inst_done_in, input, 1 bit: a one-cycle pulse meaning the fetch data is valid.
REQ-009 The block SHALL have port mem_ctrl_inst_in, input, 32 bits: the fetched instruction.
REQ-010 The block SHALL have port mem_ctrl_enable_out, output, 1 bit: the fetch request, registered.
REQ-011 The block SHALL have port mem_ctrl_addr_out, output, 32 bits: the fetch address, registered.
REQ-012 The block SHALL have port id_ready_in, input, 1 bit: ID accepts an instruction this cycle.
REQ-013 The block SHALL have port inst_valid_out, output, 1 bit: pc_out and inst_out are valid.
REQ-014 The block SHALL have port pc_out, output, 32 bits: the PC of the presented instruction.
REQ-015 The block SHALL have port inst_out, output, 32 bits: the presented instruction.
REQ-016 The block SHALL have port stall_from_if, output, 1 bit: equal to !inst_valid_out.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ (fetch outstanding) and DISCARD (outstanding fetch whose data will be dropped).
REQ-018 The block SHALL hold fetch_pc; the queue SHALL store {pc, inst} pairs with count width clog2(QUEUE_DEPTH)+1.
REQ-019 IDLE to REQ SHALL occur when branch_enable=0, mem_ctrl_busy_mem_in=0 and count<QUEUE_DEPTH; on that edge mem_ctrl_enable_out<=1 and mem_ctrl_addr_out<=fetch_pc.
REQ-020 In REQ and DISCARD, mem_ctrl_enable_out and mem_ctrl_addr_out SHALL hold their values until mem_ctrl_inst_done_in.
REQ-021 On done in REQ without a branch, the block SHALL push {mem_ctrl_addr_out, mem_ctrl_inst_in}, set fetch_pc<=fetch_pc+4 (mod 2^32), drop enable and return to IDLE.
REQ-022 On done in DISCARD, the block SHALL drop the data, drop enable and return to IDLE.
REQ-023 The issue rule SHALL be that a request is issued only when a slot is free, so a push never overflows; with a pop in the same cycle, count is unchanged.
REQ-024 A pop SHALL occur when inst_valid_out=1 and id_ready_in=1; head pointer and count update on the edge.
REQ-025 inst_valid_out SHALL equal (count!=0); pc_out and inst_out SHALL come from the head entry; when the queue is empty they SHALL be 0.
REQ-026 On branch_enable, the block SHALL clear the queue (count<=0, pointers<=0), set fetch_pc<=branch_target, and go REQ to DISCARD; DISCARD and IDLE keep their state.
REQ-027 branch_enable SHALL take priority over a simultaneous push, pop or done; a done in the branch cycle is dropped and the state goes to IDLE.
REQ-028 Pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-029 Latency from done to inst_valid_out SHALL be one cycle with the queue empty, without the bypass.

Reset
REQ-030 rst_n=0 SHALL, asynchronously, set state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, mem_ctrl_enable_out=0 and mem_ctrl_addr_out=0.
REQ-031 During reset, inst_valid_out=0, pc_out=0, inst_out=0 and stall_from_if=1.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch without entering DISCARD; a done arriving while rst_n=0 SHALL be ignored.

Configuration
REQ-033 With macro IF_BYPASS_EN defined, when count=0, state=REQ, done=1 and branch_enable=0, the block SHALL present the instruction combinationally the same cycle (inst_valid_out=1, pc_out=mem_ctrl_addr_out, inst_out=mem_ctrl_inst_in); if id_ready_in=1 it is consumed and not pushed, otherwise it is pushed.
REQ-034 Without IF_BYPASS_EN, REQ-029 SHALL apply and outputs SHALL depend only on registers.

Verification
REQ-035 Scenario reset: release rst_n, RESET_PC=0, mem idle -> enable=1 and addr=0 one cycle later; done with inst 32'h00000013 -> next cycle valid=1, pc_out=0, inst_out=32'h00000013.
REQ-036 Scenario fill: id_ready_in=0, QUEUE_DEPTH=4 -> fetches at 0, 4, 8, 12, then enable stays 0, count=4, no fifth request.
REQ-037 Scenario branch mid-fetch: branch_enable=1 with target 32'h100 during REQ at addr 8 -> DISCARD, valid=0; done dropped; next request addr=32'h100.
REQ-038 Scenario MEM contention: mem_ctrl_busy_mem_in=1 in IDLE -> no request; deassert -> request next cycle at unchanged fetch_pc.
REQ-039 Scenario simultaneous events: push and pop at count=3 -> count stays 3 and order is preserved; wrap after 8 pushes at depth 4 -> PCs appear in order 0..28.
REQ-040 Scenario bypass: with IF_BYPASS_EN defined, empty queue, done with id_ready_in=1 -> valid=1 the same cycle and count stays 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a {pc, inst} prefetch queue.
// Optional same-cycle bypass of fetch data when the queue is empty: IF_BYPASS_EN.
module if_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_enable,
  input  logic [31:0] branch_target,
  input  logic        mem_ctrl_busy_mem_in,
  input  logic        mem_ctrl_inst_done_in,
  input  logic [31:0] mem_ctrl_inst_in,
  output logic        mem_ctrl_enable_out,
  output logic [31:0] mem_ctrl_addr_out,
  input  logic        id_ready_in,
  output logic        inst_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        stall_from_if
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          en_q, en_d;
  logic [31:0]   addr_q, addr_d;

  logic [31:0] pc_mem   [QUEUE_DEPTH];
  logic [31:0] inst_mem [QUEUE_DEPTH];

  logic q_valid;
  logic done_req;
  logic push;
  logic pop;
  logic issue;

  assign q_valid  = (count_q != '0);
  assign done_req = (state_q == S_REQ) && mem_ctrl_inst_done_in
                    && !branch_enable;
  assign pop      = q_valid && id_ready_in && !branch_enable;
  assign issue    = (state_q == S_IDLE) && !branch_enable
                    && !mem_ctrl_busy_mem_in && (count_q < DEPTH_C);

`ifdef IF_BYPASS_EN
  logic byp;
  assign byp  = done_req && !q_valid;
  // A bypassed instruction taken by ID never occupies a slot
  assign push = done_req && !(byp && id_ready_in);

  always_comb begin
    inst_valid_out = q_valid || byp;
    pc_out         = '0;
    inst_out       = '0;
    unique case (1'b1)
      q_valid: begin
        pc_out   = pc_mem[head_q];
        inst_out = inst_mem[head_q];
      end
      byp: begin
        pc_out   = addr_q;
        inst_out = mem_ctrl_inst_in;
      end
      default: ;
    endcase
  end
`else
  assign push = done_req;

  always_comb begin
    inst_valid_out = q_valid;
    pc_out         = '0;
    inst_out       = '0;
    if (q_valid) begin
      pc_out   = pc_mem[head_q];
      inst_out = inst_mem[head_q];
    end
  end
`endif

  assign stall_from_if       = !inst_valid_out;
  assign mem_ctrl_enable_out = en_q;
  assign mem_ctrl_addr_out   = addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    en_d       = en_q;
    addr_d     = addr_q;
    if (branch_enable) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = branch_target;
      // A done landing in the flush cycle closes the fetch outright
      if (state_q != S_IDLE && mem_ctrl_inst_done_in) begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end else if (state_q == S_REQ) begin
        state_d = S_DISC;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_d = S_REQ;
            en_d    = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (mem_ctrl_inst_done_in) begin
            state_d    = S_IDLE;
            en_d       = 1'b0;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        S_DISC: begin
          if (mem_ctrl_inst_done_in) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end
      endcase
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= addr_q;
      inst_mem[tail_q] <= mem_ctrl_inst_in;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (depth 4, reset PC 0).
// Inputs change on the falling edge; outputs are checked there too.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = '0;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic [31:0] inst = '0;
  logic        en;
  logic [31:0] addr;
  logic        id_ready = 1'b0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst_o;
  logic        stall;

  int tests = 0;
  int fails = 0;

  if_fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .branch_enable         (branch),
    .branch_target         (target),
    .mem_ctrl_busy_mem_in  (busy),
    .mem_ctrl_inst_done_in (done),
    .mem_ctrl_inst_in      (inst),
    .mem_ctrl_enable_out   (en),
    .mem_ctrl_addr_out     (addr),
    .id_ready_in           (id_ready),
    .inst_valid_out        (valid),
    .pc_out                (pc),
    .inst_out              (inst_o),
    .stall_from_if         (stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_done(input logic [31:0] d);
    done = 1'b1;
    inst = d;
    tick();
    done = 1'b0;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    branch   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    id_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    rst_n = 1'b0;
    tick();
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL rst_valid: got %b want 0", valid);
    end
    tests++;
    if (pc !== 32'h0 || inst_o !== 32'h0) begin
      fails++; $display("FAIL rst_data: got %h/%h want 0/0", pc, inst_o);
    end
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL rst_stall: got %b want 1", stall);
    end
    tests++;
    if (en !== 1'b0 || addr !== 32'h0) begin
      fails++; $display("FAIL rst_mem: got %b/%h want 0/0", en, addr);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h0) begin
      fails++; $display("FAIL first_req: got %b/%h want 1/0", en, addr);
    end
    pulse_done(32'h00000013);
    tests++;
    if (valid !== 1'b1 || pc !== 32'h0 || inst_o !== 32'h13) begin
      fails++;
      $display("FAIL first_inst: got %b/%h/%h want 1/0/13", valid, pc, inst_o);
    end
    tests++;
    if (stall !== 1'b0 || en !== 1'b0) begin
      fails++; $display("FAIL first_stall_en: got %b/%b want 0/0", stall, en);
    end
  endtask

  // Continues from test_reset: queue holds PC 0, fetch_pc is 4
  task automatic test_fill;
    logic [31:0] exp_i;
    for (int k = 1; k < 4; k++) begin
      tick();
      tests++;
      if (en !== 1'b1 || addr !== 32'(4 * k)) begin
        fails++;
        $display("FAIL fill_req%0d: got %b/%h want 1/%h", k, en, addr, 4 * k);
      end
      pulse_done(32'hA000 + 32'(k));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (en !== 1'b0) begin
        fails++; $display("FAIL fill_no5th: got en=%b want 0", en);
      end
    end
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k == 0) ? 32'h13 : 32'hA000 + 32'(k);
      tests++;
      if (valid !== 1'b1 || pc !== 32'(4 * k) || inst_o !== exp_i) begin
        fails++;
        $display("FAIL fill_pop%0d: got %b/%h/%h want 1/%h/%h",
                 k, valid, pc, inst_o, 4 * k, exp_i);
      end
      tick();
    end
    id_ready = 1'b0;
    tests++;
    if (valid !== 1'b0 || en !== 1'b1 || addr !== 32'h10) begin
      fails++;
      $display("FAIL fill_empty: got %b/%b/%h want 0/1/10", valid, en, addr);
    end
  endtask

  task automatic test_branch;
    do_reset();
    tick();
    pulse_done(32'h1);
    tick();
    pulse_done(32'h2);
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h8) begin
      fails++; $display("FAIL br_req8: got %b/%h want 1/8", en, addr);
    end
    branch = 1'b1;
    target = 32'h100;
    tick();
    branch = 1'b0;
    tests++;
    if (valid !== 1'b0 || stall !== 1'b1) begin
      fails++; $display("FAIL br_flush: got %b/%b want 0/1", valid, stall);
    end
    tests++;
    if (en !== 1'b1 || addr !== 32'h8) begin
      fails++; $display("FAIL br_hold: got %b/%h want 1/8", en, addr);
    end
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h8) begin
      fails++; $display("FAIL br_disc_wait: got %b/%h want 1/8", en, addr);
    end
    pulse_done(32'hDEAD);
    tests++;
    if (en !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL br_drop: got %b/%b want 0/0", en, valid);
    end
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h100) begin
      fails++; $display("FAIL br_target: got %b/%h want 1/100", en, addr);
    end
    pulse_done(32'h13);
    tests++;
    if (valid !== 1'b1 || pc !== 32'h100 || inst_o !== 32'h13) begin
      fails++;
      $display("FAIL br_inst: got %b/%h/%h want 1/100/13", valid, pc, inst_o);
    end
  endtask

  // Continues from test_branch: queue holds 0x100, fetch_pc 0x104
  task automatic test_busy;
    busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (en !== 1'b0) begin
        fails++; $display("FAIL busy_hold%0d: got en=%b want 0", k, en);
      end
    end
    busy = 1'b0;
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h104) begin
      fails++; $display("FAIL busy_release: got %b/%h want 1/104", en, addr);
    end
    pulse_done(32'h200);
  endtask

  // Continues from test_busy: queue holds 0x100, 0x104
  task automatic test_back_to_back;
    tick();
    pulse_done(32'h300);
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h10C || pc !== 32'h100) begin
      fails++;
      $display("FAIL bb_setup: got %b/%h/%h want 1/10c/100", en, addr, pc);
    end
    done     = 1'b1;
    inst     = 32'h400;
    id_ready = 1'b1;
    tick();
    done = 1'b0;
    tests++;
    if (valid !== 1'b1 || pc !== 32'h104 || inst_o !== 32'h200) begin
      fails++;
      $display("FAIL bb_head1: got %b/%h/%h want 1/104/200", valid, pc, inst_o);
    end
    tick();
    tests++;
    if (valid !== 1'b1 || pc !== 32'h108 || inst_o !== 32'h300) begin
      fails++;
      $display("FAIL bb_head2: got %b/%h/%h want 1/108/300", valid, pc, inst_o);
    end
    tick();
    tests++;
    if (valid !== 1'b1 || pc !== 32'h10C || inst_o !== 32'h400) begin
      fails++;
      $display("FAIL bb_head3: got %b/%h/%h want 1/10c/400", valid, pc, inst_o);
    end
    tick();
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL bb_count3: got valid=%b want 0", valid);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_wrap;
    int npop;
    logic [31:0] exp_pc;
    npop = 0;
    do_reset();
    for (int cyc = 0; cyc < 200 && npop < 8; cyc++) begin
      done     = en;
      inst     = ~addr;
      id_ready = (cyc >= 12);
      if (valid && id_ready) begin
        exp_pc = 32'(4 * npop);
        tests++;
        if (pc !== exp_pc || inst_o !== ~exp_pc) begin
          fails++;
          $display("FAIL wrap_pop%0d: got %h/%h want %h/%h",
                   npop, pc, inst_o, exp_pc, ~exp_pc);
        end
        npop++;
      end
      tick();
    end
    done     = 1'b0;
    id_ready = 1'b0;
    tests++;
    if (npop != 8) begin
      fails++; $display("FAIL wrap_timeout: got %0d pops want 8", npop);
    end
  endtask

  task automatic test_reset_midfetch;
    do_reset();
    tick();
    pulse_done(32'h5);
    tick();
    done  = 1'b1;
    inst  = 32'h7;
    rst_n = 1'b0;
    #1;
    tests++;
    if (en !== 1'b0 || addr !== 32'h0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_async: got %b/%h/%b want 0/0/0", en, addr, valid);
    end
    tick();
    done  = 1'b0;
    rst_n = 1'b1;
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL mid_rst_done_ignored: got %b want 0", valid);
    end
    tick();
    tests++;
    if (en !== 1'b1 || addr !== 32'h0) begin
      fails++; $display("FAIL mid_rst_refetch: got %b/%h want 1/0", en, addr);
    end
  endtask

`ifdef IF_BYPASS_EN
  task automatic test_bypass;
    do_reset();
    tick();
    done     = 1'b1;
    inst     = 32'h55;
    id_ready = 1'b1;
    #1;
    tests++;
    if (valid !== 1'b1 || pc !== 32'h0 || inst_o !== 32'h55) begin
      fails++;
      $display("FAIL byp_same: got %b/%h/%h want 1/0/55", valid, pc, inst_o);
    end
    tick();
    done = 1'b0;
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL byp_count0: got %b want 0", valid);
    end
    id_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_branch();
    test_busy();
    test_back_to_back();
    test_wrap();
    test_reset_midfetch();
`ifdef IF_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
